instr_fetch_ctrl: RTL and testbench

Instruction fetch sequencer for the 16-cell instruction ROM.
- Owns the program counter and drives the ROM output-enable and address.
- Latches the 16-bit instruction word and splits it into register-select, opcode and data fields.
- Presents each instruction to the execute stage over a valid/ready handshake.
- Accepts jump redirects from the execute stage.

---
 rtl/instr_fetch_ctrl_pkg.sv | 24 ++
 rtl/instr_fetch_ctrl_pc_reg.sv | 48 ++++
 rtl/instr_fetch_ctrl.sv | 167 ++++++++++++++++
 tb/tb_instr_fetch_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_ctrl_pkg.sv
// ifc_pkg: shared definitions for the instruction fetch sequencer.
//   - ifc_state_e : FSM state encoding (IDLE/FETCH/ISSUE/HALT)
//   - instruction field bit positions within the 16-bit word
//   - default halt opcode, which only matters when IFC_HALT_OPCODE_EN is defined
package ifc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ISSUE = 2'd2,
    ST_HALT  = 2'd3
  } ifc_state_e;

  // Instruction word layout: [15:14] unused, [13:12] reg_sel, [11:8] opcode, [7:0] imm
  localparam int REG_SEL_MSB = 13;
  localparam int REG_SEL_LSB = 12;
  localparam int OPC_MSB     = 11;
  localparam int OPC_LSB     = 8;
  localparam int IMM_MSB     = 7;
  localparam int IMM_LSB     = 0;

  localparam logic [3:0] DEFAULT_HALT_OPCODE = 4'hF;

endpackage

// File: rtl/instr_fetch_ctrl_pc_reg.sv
// ifc_pc_reg: program counter for the fetch sequencer.
// Load priority: reset, start load (START_ADDR), jump load, increment.
// The increment wraps at ROM_DEPTH-1; an out-of-range jump target loads 0.
// Ports:
//   clk, rst    : clock, synchronous active-high reset (pc <= START_ADDR)
//   load_start  : load START_ADDR
//   load_jmp    : load jmp_addr (clamped to 0 when >= ROM_DEPTH)
//   inc         : advance to the next ROM cell with wrap
//   jmp_addr    : jump target
//   pc          : current program counter
module ifc_pc_reg #(
  parameter int                ROM_DEPTH  = 16,
  parameter int                ADDR_W     = 5,
  parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              load_jmp,
  input  logic              inc,
  input  logic [ADDR_W-1:0] jmp_addr,
  output logic [ADDR_W-1:0] pc
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROM_DEPTH - 1);

  logic                 jmp_in_range;
  logic [ADDR_W-1:0]    jmp_target;
  logic [ADDR_W-1:0]    pc_next_seq;

  // Compare at 32 bits so a ROM_DEPTH of 2**ADDR_W still behaves correctly.
  assign jmp_in_range = (32'(jmp_addr) < 32'(ROM_DEPTH));
  assign jmp_target   = jmp_in_range ? jmp_addr : '0;
  assign pc_next_seq  = (pc == LAST_ADDR) ? '0 : pc + ADDR_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= START_ADDR;
    end else if (load_start) begin
      pc <= START_ADDR;
    end else if (load_jmp) begin
      pc <= jmp_target;
    end else if (inc) begin
      pc <= pc_next_seq;
    end
  end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: fetch sequencer for the 16-cell instruction ROM.
// Reads one ROM cell per instruction, latches it, and offers it to the
// execute stage; accepts jump redirects on the handshake.
//
// Optional feature (macro IFC_HALT_OPCODE_EN): an instruction whose opcode
// equals HALT_OPCODE parks the sequencer in HALT after its handshake.
// Without the macro HALT is unreachable and halted is constant 0.
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   start, stop     : begin fetching from START_ADDR / abort to IDLE
//   rom_oe, rom_addr: ROM read strobe and address (addr is 0 when not fetching)
//   rom_data        : ROM cell contents, combinational from rom_addr
//   instr_valid     : instruction/fields are valid (ISSUE state)
//   instr_ready     : execute stage accepts the instruction
//   instr           : latched instruction word
//   reg_sel/opcode/imm : slices of instr
//   jmp_en, jmp_addr: redirect, honoured only on the handshake cycle
//   pc              : address of the next fetch
//   busy, halted    : in FETCH/ISSUE, in HALT
//   state           : debug view of the FSM state (ifc_state_e encoding)
//
// Handshake: an instruction transfers on every rising edge where
// instr_valid && instr_ready are both high. While instr_valid is high and
// instr_ready low, instr and its fields are held unchanged; instr_valid never
// drops without a transfer except on stop or rst.
module instr_fetch_ctrl
  import ifc_pkg::*;
#(
  parameter int                ROM_DEPTH   = 16,
  parameter int                ADDR_W      = 5,
  parameter int                DATA_W      = 16,
  parameter logic [ADDR_W-1:0] START_ADDR  = '0,
  parameter logic [3:0]        HALT_OPCODE = DEFAULT_HALT_OPCODE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  output logic              rom_oe,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic [1:0]        reg_sel,
  output logic [3:0]        opcode,
  output logic [7:0]        imm,
  input  logic              jmp_en,
  input  logic [ADDR_W-1:0] jmp_addr,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic [1:0]        state
);

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] FETCH = ST_FETCH;
  localparam logic [1:0] ISSUE = ST_ISSUE;
  localparam logic [1:0] HALT  = ST_HALT;

`ifdef IFC_HALT_OPCODE_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic [1:0]        state_q;
  logic [1:0]        state_d;
  logic [DATA_W-1:0] instr_q;
  logic              latch_instr;
  logic              pc_load_start;
  logic              pc_load_jmp;
  logic              pc_inc;
  logic              is_halt_instr;

  // With the feature compiled out this is constant 0, so HALT is never entered.
  assign is_halt_instr = HALT_EN && (instr_q[OPC_MSB:OPC_LSB] == HALT_OPCODE);

  // Next-state and PC control. stop always lands in IDLE, but a handshake
  // coinciding with stop still completes (including its jump).
  always_comb begin
    state_d       = state_q;
    latch_instr   = 1'b0;
    pc_load_start = 1'b0;
    pc_load_jmp   = 1'b0;
    pc_inc        = 1'b0;
    case (state_q)
      IDLE: begin
        if (!stop && start) begin
          state_d       = FETCH;
          pc_load_start = 1'b1;
        end
      end
      FETCH: begin
        if (stop) begin
          state_d = IDLE;
        end else begin
          latch_instr = 1'b1;
          pc_inc      = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (instr_ready) begin
          if (is_halt_instr) begin
            // Jump on a halt handshake is dropped; pc is held.
            state_d = stop ? IDLE : HALT;
          end else begin
            pc_load_jmp = jmp_en;
            state_d     = stop ? IDLE : FETCH;
          end
        end else if (stop) begin
          state_d = IDLE;
        end
      end
      HALT: begin
        if (stop) begin
          state_d = IDLE;
        end else if (start) begin
          state_d       = FETCH;
          pc_load_start = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      if (latch_instr) begin
        instr_q <= rom_data;
      end
    end
  end

  ifc_pc_reg #(
    .ROM_DEPTH  (ROM_DEPTH),
    .ADDR_W     (ADDR_W),
    .START_ADDR (START_ADDR)
  ) u_pc_reg (
    .clk        (clk),
    .rst        (rst),
    .load_start (pc_load_start),
    .load_jmp   (pc_load_jmp),
    .inc        (pc_inc),
    .jmp_addr   (jmp_addr),
    .pc         (pc)
  );

  assign rom_oe      = (state_q == FETCH);
  assign rom_addr    = (state_q == FETCH) ? pc : '0;
  assign instr_valid = (state_q == ISSUE);
  assign busy        = (state_q == FETCH) || (state_q == ISSUE);
  assign halted      = HALT_EN && (state_q == HALT);
  assign state       = state_q;

  assign instr   = instr_q;
  assign reg_sel = instr_q[REG_SEL_MSB:REG_SEL_LSB];
  assign opcode  = instr_q[OPC_MSB:OPC_LSB];
  assign imm     = instr_q[IMM_MSB:IMM_LSB];

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: directed steps followed by a randomized run
// checked against a transaction-level model (expected fetch address plus a
// queue of fetched words). Inputs change #1 after each rising edge and
// outputs are checked at that same point.
module tb_instr_fetch_ctrl;
  import ifc_pkg::*;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 16;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              rom_oe;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic              instr_valid;
  logic              instr_ready = 1'b0;
  logic [DATA_W-1:0] instr;
  logic [1:0]        reg_sel;
  logic [3:0]        opcode;
  logic [7:0]        imm;
  logic              jmp_en = 1'b0;
  logic [ADDR_W-1:0] jmp_addr = '0;
  logic [ADDR_W-1:0] pc;
  logic              busy;
  logic              halted;
  logic [1:0]        state;

  logic [DATA_W-1:0] rom [DEPTH];
  assign rom_data = (rom_oe && rom_addr < ADDR_W'(DEPTH)) ? rom[rom_addr[3:0]] : '0;

  instr_fetch_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .rom_oe      (rom_oe),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .reg_sel     (reg_sel),
    .opcode      (opcode),
    .imm         (imm),
    .jmp_en      (jmp_en),
    .jmp_addr    (jmp_addr),
    .pc          (pc),
    .busy        (busy),
    .halted      (halted),
    .state       (state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard state for the randomized run
  logic [DATA_W-1:0] exp_q[$];
  int                exp_pc;
  int                fetch_cnt;
  bit                prev_fetch;
  bit                prev_hs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  // Driver: advance one clock and settle just after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) rom[i] = 16'h2000 + 16'(i);
    rom[0] = 16'h3105;
    rom[1] = 16'h2207;
    rom[2] = 16'h1309;
    rom[3] = 16'h0A33;
    rom[4] = 16'h0F00;

    // Reset, then idle
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("idle_rom_oe", 32'(rom_oe), 0);
      chk("idle_valid", 32'(instr_valid), 0);
      chk("idle_pc", 32'(pc), 0);
      chk("idle_busy", 32'(busy), 0);
    end
    chk("idle_rom_addr", 32'(rom_addr), 0);
    chk("idle_instr", 32'(instr), 0);
    chk("idle_halted", 32'(halted), 0);
    chk("idle_state", 32'(state), 32'(ST_IDLE));

    // Start pulse at edge 0; ready held low to stall the first issue
    start = 1'b1;
    step();
    chk("c1_rom_oe", 32'(rom_oe), 1);
    chk("c1_rom_addr", 32'(rom_addr), 0);
    chk("c1_busy", 32'(busy), 1);
    start = 1'b0;
    instr_ready = 1'b0;
    step();
    chk("c2_valid", 32'(instr_valid), 1);
    chk("c2_reg_sel", 32'(reg_sel), 3);
    chk("c2_opcode", 32'(opcode), 1);
    chk("c2_imm", 32'(imm), 5);
    chk("c2_pc", 32'(pc), 1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stall_valid", 32'(instr_valid), 1);
      chk("stall_instr", 32'(instr), 32'h3105);
      chk("stall_rom_oe", 32'(rom_oe), 0);
      chk("stall_pc", 32'(pc), 1);
    end
    instr_ready = 1'b1;
    step();
    chk("rel_fetch_oe", 32'(rom_oe), 1);
    chk("rel_fetch_addr", 32'(rom_addr), 1);
    start = 1'b1;  // ignored while busy
    step();
    start = 1'b0;
    chk("i1_instr", 32'(instr), 32'h2207);
    chk("i1_pc", 32'(pc), 2);
    step();
    chk("f2_addr", 32'(rom_addr), 2);
    step();
    chk("i2_instr", 32'(instr), 32'h1309);
    chk("i2_pc_after_3", 32'(pc), 3);

    // Jump on handshake to 9, then to out-of-range 20
    jmp_en = 1'b1;
    jmp_addr = 5'd9;
    step();
    chk("jmp9_addr", 32'(rom_addr), 9);
    jmp_en = 1'b0;
    step();
    chk("jmp9_instr", 32'(instr), 32'(rom[9]));
    chk("jmp9_pc", 32'(pc), 10);
    jmp_en = 1'b1;
    jmp_addr = 5'd20;
    step();
    chk("jmp20_oe", 32'(rom_oe), 1);
    chk("jmp20_addr", 32'(rom_addr), 0);

    // Jump outside the handshake cycle is ignored
    jmp_addr = 5'd7;
    instr_ready = 1'b0;
    step();
    chk("nojmp_fetch_pc", 32'(pc), 1);
    step();
    chk("nojmp_stall_pc", 32'(pc), 1);
    chk("nojmp_stall_valid", 32'(instr_valid), 1);

    // Jump to 14, run through 15, wrap to 0
    jmp_addr = 5'd14;
    instr_ready = 1'b1;
    step();
    chk("f14_addr", 32'(rom_addr), 14);
    jmp_en = 1'b0;
    step();
    step();
    chk("f15_addr", 32'(rom_addr), 15);
    step();
    chk("wrap_pc", 32'(pc), 0);
    step();
    chk("wrap_fetch_addr", 32'(rom_addr), 0);
    chk("wrap_fetch_oe", 32'(rom_oe), 1);

    // stop while stalled in ISSUE
    instr_ready = 1'b0;
    step();
    chk("pre_stop_valid", 32'(instr_valid), 1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop_valid", 32'(instr_valid), 0);
    chk("stop_busy", 32'(busy), 0);
    chk("stop_state", 32'(state), 32'(ST_IDLE));
    chk("stop_pc_held", 32'(pc), 1);

    // stop and start together in IDLE: stay idle
    start = 1'b1;
    stop = 1'b1;
    step();
    start = 1'b0;
    stop = 1'b0;
    chk("stopstart_oe", 32'(rom_oe), 0);
    chk("stopstart_busy", 32'(busy), 0);

    // Halt-opcode program: cells 0..4 with cell 4 = 16'h0F00
    instr_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("halt_prog_addr", 32'(rom_addr), 32'(k));
      step();
      chk("halt_prog_instr", 32'(instr), 32'(rom[k]));
      if (k < 4) step();
    end
    chk("halt_instr_opc", 32'(opcode), 32'hF);
    step();
`ifdef IFC_HALT_OPCODE_EN
    for (int i = 0; i < 3; i++) begin
      chk("halt_halted", 32'(halted), 1);
      chk("halt_no_fetch", 32'(rom_oe), 0);
      chk("halt_busy", 32'(busy), 0);
      chk("halt_pc", 32'(pc), 5);
      step();
    end
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_oe", 32'(rom_oe), 1);
    chk("restart_addr", 32'(rom_addr), 0);
    chk("restart_halted", 32'(halted), 0);
`else
    chk("nohalt_halted", 32'(halted), 0);
    chk("nohalt_oe", 32'(rom_oe), 1);
    chk("nohalt_addr", 32'(rom_addr), 5);
`endif
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop_fetch_state", 32'(state), 32'(ST_IDLE));

    // Reset mid-fetch has priority
    start = 1'b1;
    step();
    start = 1'b0;
    chk("rstmid_fetch", 32'(rom_oe), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstmid_state", 32'(state), 32'(ST_IDLE));
    chk("rstmid_instr", 32'(instr), 0);
    chk("rstmid_pc", 32'(pc), 0);

    // Randomized run against the transaction model
    for (int i = 0; i < DEPTH; i++) begin
      rom[i] = 16'($urandom);
      if (rom[i][11:8] == 4'hF) rom[i][11:8] = 4'hE;
    end
    exp_pc = 0;
    fetch_cnt = 0;
    prev_fetch = 1'b0;
    prev_hs = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      instr_ready = 1'($urandom_range(0, 1));
      jmp_en = ($urandom_range(0, 3) == 0);
      jmp_addr = 5'($urandom_range(0, 31));
      if (prev_hs) chk("rnd_fetch_after_hs", 32'(rom_oe), 1);
      if (prev_fetch) chk("rnd_valid_after_fetch", 32'(instr_valid), 1);
      prev_fetch = rom_oe;
      prev_hs = instr_valid && instr_ready;
      if (rom_oe) begin
        chk("rnd_fetch_addr", 32'(rom_addr), 32'(exp_pc));
        exp_q.push_back(rom[exp_pc]);
        exp_pc = (exp_pc + 1) % DEPTH;
        fetch_cnt++;
      end
      if (instr_valid) begin
        chk("rnd_issue_pc", 32'(pc), 32'(exp_pc));
        if (exp_q.size() == 0) begin
          chk("rnd_issue_unexpected", 32'(instr_valid), 0);
        end else begin
          chk("rnd_issue_instr", 32'(instr), 32'(exp_q[0]));
          if (instr_ready) begin
            void'(exp_q.pop_front());
            if (jmp_en) exp_pc = (int'(jmp_addr) >= DEPTH) ? 0 : int'(jmp_addr);
          end
        end
      end
      step();
    end
    chk("rnd_progress", 32'(fetch_cnt > 60), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
